// File: rtl/conv_mac_tree_acc_if.sv
// conv_mac_tree_acc_if: beat/config inputs and result outputs of the MAC tree accumulator
interface conv_mac_tree_acc_if #(
    parameter int TM = 4,
    parameter int TN = 16,
    parameter int DW = 16,
    parameter int OUT_W = 16
);
    logic                   in_valid;
    logic                   in_first;
    logic                   in_last;
    logic [5:0]             cfg_shift;
    logic                   cfg_relu;
    logic [TN*DW-1:0]       data_in;
    logic [TM*TN*DW-1:0]    weight_in;
    logic                   out_valid;
    logic [TM*OUT_W-1:0]    out_data;
    logic                   busy;
    modport master (
        output in_valid, in_first, in_last, cfg_shift, cfg_relu, data_in, weight_in,
        input  out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_first, in_last, cfg_shift, cfg_relu, data_in, weight_in,
        output out_valid, out_data, busy
    );
endinterface

// File: rtl/conv_mac_tree_acc.sv
// conv_mac_tree_acc: TMxTN signed MAC array, pipelined adder tree, per-row accumulator
// with arithmetic shift, optional ReLU and saturation on the last beat of each group.
module conv_mac_tree_acc #(
    parameter int TM = 4,
    parameter int TN = 16,
    parameter int DW = 16,
    parameter int ACC_W = 40,
    parameter int OUT_W = 16
) (
    input logic clk,
    input logic rst,
    conv_mac_tree_acc_if.slave bus
);
    localparam int L2 = $clog2(TN);
    localparam int TW = 2*DW + L2;
    localparam int D = L2 + 1;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic signed [2*DW-1:0]  prod [TM][TN];
    // heap-ordered tree per row: leaves at TN..2TN-1, root at 1; every node is a register
    logic signed [TW-1:0]    t [TM][1:2*TN-1];
    logic [D:0]              vld, lst, rl;
    logic [L2:0]             fst;
    logic [5:0]              sh [D+1];
    logic signed [ACC_W-1:0] acc [TM];
    logic signed [ACC_W-1:0] sr [TM];
    logic signed [ACC_W-1:0] cl [TM];
    logic [TM*OUT_W-1:0]     q;
    always_comb begin
        for (int m = 0; m < TM; m++) begin
            for (int n = 0; n < TN; n++)
                prod[m][n] = (2*DW)'($signed(bus.data_in[n*DW +: DW])) *
                             (2*DW)'($signed(bus.weight_in[(m*TN+n)*DW +: DW]));
            sr[m] = acc[m] >>> sh[D];
            cl[m] = (rl[D] && sr[m][ACC_W-1]) ? '0 : sr[m];
            q[m*OUT_W +: OUT_W] = cl[m] > MAXV ? MAXV[OUT_W-1:0] :
                                  cl[m] < MINV ? MINV[OUT_W-1:0] : cl[m][OUT_W-1:0];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld <= '0;
            lst <= '0;
            rl <= '0;
            fst <= '0;
            for (int i = 0; i <= D; i++) sh[i] <= '0;
            for (int m = 0; m < TM; m++) begin
                acc[m] <= '0;
                for (int i = 1; i < 2*TN; i++) t[m][i] <= '0;
            end
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
        end else begin
            vld <= {vld[D-1:0], bus.in_valid};
            lst <= {lst[D-1:0], bus.in_last};
            rl <= {rl[D-1:0], bus.cfg_relu};
            fst <= {fst[L2-1:0], bus.in_first};
            sh[0] <= bus.cfg_shift;
            for (int i = 1; i <= D; i++) sh[i] <= sh[i-1];
            for (int m = 0; m < TM; m++) begin
                for (int n = 0; n < TN; n++) t[m][TN+n] <= TW'(prod[m][n]);
                for (int i = 1; i < TN; i++) t[m][i] <= t[m][2*i] + t[m][2*i+1];
                if (vld[L2]) acc[m] <= (fst[L2] ? '0 : acc[m]) + ACC_W'(t[m][1]);
            end
            bus.out_valid <= vld[D] & lst[D];
            if (vld[D] & lst[D]) bus.out_data <= q;
        end
    end
    assign bus.busy = (|vld) | bus.out_valid;
endmodule

// File: tb/tb_conv_mac_tree_acc.sv
// tb_conv_mac_tree_acc: directed and randomized checks of conv_mac_tree_acc against
// a dot-product/accumulate reference model with cycle-accurate output timing.
module tb_conv_mac_tree_acc;
    localparam int TM = 4, TN = 16, DW = 16, ACC_W = 40, OUT_W = 16;
    localparam int LAT = $clog2(TN) + 3;
    localparam longint MAXO = (longint'(1) << (OUT_W-1)) - 1;
    localparam longint MINO = -(longint'(1) << (OUT_W-1));
    typedef struct { logic [TM*OUT_W-1:0] v; int c; } ev_t;

    logic clk = 0, rst = 0;
    always #5 clk = ~clk;

    conv_mac_tree_acc_if #(.TM(TM), .TN(TN), .DW(DW), .OUT_W(OUT_W)) bus();
    conv_mac_tree_acc #(.TM(TM), .TN(TN), .DW(DW), .ACC_W(ACC_W), .OUT_W(OUT_W))
        dut (.clk(clk), .rst(rst), .bus(bus));

    ev_t got_q[$], exp_q[$];
    int cyc = 0, vectors = 0, fails = 0;
    longint macc [TM];
    logic [TN*DW-1:0] dv;
    logic [TM*TN*DW-1:0] wv;
    logic [TM*OUT_W-1:0] want;

    // reference: whole-beat dot products accumulated per group, result due LAT cycles later
    always @(negedge clk) begin
        longint dot, r;
        logic [TM*OUT_W-1:0] v;
        cyc++;
        if (bus.out_valid === 1'b1) got_q.push_back('{bus.out_data, cyc});
        if (!rst) begin
            foreach (macc[m]) macc[m] = 0;
            while (exp_q.size() > 0 && exp_q[$].c > cyc) void'(exp_q.pop_back());
        end else if (bus.in_valid) begin
            v = '0;
            for (int m = 0; m < TM; m++) begin
                dot = 0;
                for (int n = 0; n < TN; n++)
                    dot += longint'($signed(bus.data_in[n*DW +: DW])) *
                           longint'($signed(bus.weight_in[(m*TN+n)*DW +: DW]));
                macc[m] = (bus.in_first ? 0 : macc[m]) + dot;
                r = macc[m] >>> bus.cfg_shift;
                if (bus.cfg_relu && r < 0) r = 0;
                if (r > MAXO) r = MAXO;
                else if (r < MINO) r = MINO;
                v[m*OUT_W +: OUT_W] = r[OUT_W-1:0];
            end
            if (bus.in_last) exp_q.push_back('{v, cyc + LAT});
        end
    end

    task automatic beat(input bit f, input bit l, input logic [5:0] s, input bit r);
        bus.in_valid = 1; bus.in_first = f; bus.in_last = l;
        bus.cfg_shift = s; bus.cfg_relu = r;
        bus.data_in = dv; bus.weight_in = wv;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_uniform(input int d, input int w);
        for (int n = 0; n < TN; n++) dv[n*DW +: DW] = DW'(d);
        for (int i = 0; i < TM*TN; i++) wv[i*DW +: DW] = DW'(w);
    endtask

    task automatic set_random();
        for (int n = 0; n < TN; n++) dv[n*DW +: DW] = DW'($urandom);
        for (int i = 0; i < TM*TN; i++) wv[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic set_want(input int val);
        for (int m = 0; m < TM; m++) want[m*OUT_W +: OUT_W] = OUT_W'(val);
    endtask

    task automatic test_reset();
        rst = 0;
        set_random();
        bus.in_valid = 1; bus.in_first = 1; bus.in_last = 1;
        bus.cfg_shift = 0; bus.cfg_relu = 0; bus.data_in = dv; bus.weight_in = wv;
        repeat (3) begin
            @(posedge clk); #1;
            vectors++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
            vectors++; if (bus.out_data !== '0) begin fails++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
            vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        end
        rst = 1;
        idle(LAT + 3);
        vectors++; if (got_q.size() != 0) begin fails++; $display("FAIL reset_no_output got %0d pulses want 0", got_q.size()); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_single();
        set_uniform(2, 3);
        beat(1, 1, 0, 0);
        vectors++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", bus.busy); end
        idle(LAT + 5);
        vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy got %b want 0", bus.busy); end
        set_want(96);
        vectors++; if (got_q.size() != 1) begin fails++; $display("FAIL single_count got %0d want 1", got_q.size()); end
        else begin
            vectors++; if (got_q[0].v !== want) begin fails++; $display("FAIL single_value got %h want %h", got_q[0].v, want); end
        end
        vectors++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL single_model_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i].v !== exp_q[i].v || got_q[i].c != exp_q[i].c) begin fails++; $display("FAIL single_model[%0d] got %h@%0d want %h@%0d", i, got_q[i].v, got_q[i].c, exp_q[i].v, exp_q[i].c); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_group();
        for (int n = 0; n < TN; n++) dv[n*DW +: DW] = DW'(1);
        for (int m = 0; m < TM; m++)
            for (int n = 0; n < TN; n++) wv[(m*TN+n)*DW +: DW] = DW'(m + 1);
        for (int b = 0; b < 4; b++) beat(b == 0, b == 3, 2, 0);
        idle(LAT + 5);
        for (int m = 0; m < TM; m++) want[m*OUT_W +: OUT_W] = OUT_W'(16*(m+1));
        vectors++; if (got_q.size() != 1) begin fails++; $display("FAIL group_count got %0d want 1", got_q.size()); end
        else begin
            vectors++; if (got_q[0].v !== want) begin fails++; $display("FAIL group_value got %h want %h", got_q[0].v, want); end
        end
        vectors++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL group_model_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i].v !== exp_q[i].v || got_q[i].c != exp_q[i].c) begin fails++; $display("FAIL group_model[%0d] got %h@%0d want %h@%0d", i, got_q[i].v, got_q[i].c, exp_q[i].v, exp_q[i].c); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        int wants [3] = '{32767, 0, -32768};
        set_uniform(32767, 32767);  beat(1, 1, 0, 0);
        set_uniform(32767, -32767); beat(1, 1, 0, 1);
        set_uniform(32767, -32767); beat(1, 1, 0, 0);
        idle(LAT + 5);
        vectors++; if (got_q.size() != 3) begin fails++; $display("FAIL sat_count got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            set_want(wants[i]);
            vectors++; if (got_q[i].v !== want) begin fails++; $display("FAIL sat_value[%0d] got %h want %h", i, got_q[i].v, want); end
        end
        vectors++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL sat_model_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i].v !== exp_q[i].v || got_q[i].c != exp_q[i].c) begin fails++; $display("FAIL sat_model[%0d] got %h@%0d want %h@%0d", i, got_q[i].v, got_q[i].c, exp_q[i].v, exp_q[i].c); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 8; b++) begin
            set_random();
            beat(1, 1, 6'($urandom_range(0, 24)), 1'($urandom_range(0, 1)));
        end
        idle(LAT + 5);
        vectors++; if (got_q.size() != 8) begin fails++; $display("FAIL stream_count got %0d want 8", got_q.size()); end
        for (int i = 1; i < got_q.size(); i++) begin
            vectors++; if (got_q[i].c != got_q[0].c + i) begin fails++; $display("FAIL stream_gap[%0d] got cycle %0d want %0d", i, got_q[i].c, got_q[0].c + i); end
        end
        vectors++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL stream_model_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i].v !== exp_q[i].v || got_q[i].c != exp_q[i].c) begin fails++; $display("FAIL stream_model[%0d] got %h@%0d want %h@%0d", i, got_q[i].v, got_q[i].c, exp_q[i].v, exp_q[i].c); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_groups();
        for (int g = 0; g < 24; g++) begin
            int len = $urandom_range(1, 4);
            bit drop = ($urandom_range(0, 4) == 0);
            for (int b = 0; b < len; b++) begin
                set_random();
                beat(b == 0, b == len - 1 && !drop, 6'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        idle(LAT + 5);
        vectors++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_model_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i].v !== exp_q[i].v || got_q[i].c != exp_q[i].c) begin fails++; $display("FAIL rand_model[%0d] got %h@%0d want %h@%0d", i, got_q[i].v, got_q[i].c, exp_q[i].v, exp_q[i].c); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        set_random();
        beat(1, 1, 3, 0);
        beat(1, 1, 3, 0);
        rst = 0;
        idle(1);
        rst = 1;
        vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy got %b want 0", bus.busy); end
        set_uniform(1, 1);
        beat(0, 1, 0, 0);
        idle(LAT + 5);
        set_want(16);
        vectors++; if (got_q.size() != 1) begin fails++; $display("FAIL mid_reset_count got %0d want 1", got_q.size()); end
        else begin
            vectors++; if (got_q[0].v !== want) begin fails++; $display("FAIL mid_reset_value got %h want %h", got_q[0].v, want); end
        end
        vectors++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL mid_model_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i].v !== exp_q[i].v || got_q[i].c != exp_q[i].c) begin fails++; $display("FAIL mid_model[%0d] got %h@%0d want %h@%0d", i, got_q[i].v, got_q[i].c, exp_q[i].v, exp_q[i].c); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0;
        bus.cfg_shift = 0; bus.cfg_relu = 0; bus.data_in = '0; bus.weight_in = '0;
        test_reset();
        test_single();
        test_group();
        test_saturation();
        test_back_to_back();
        test_random_groups();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
